// File: rtl/mips_mem_pkg.sv
// Shared data-memory types for the MEM stage, store buffer and data memory.
// Word-addressed; one sb_entry_t per posted store.
package mips_mem_pkg;

    localparam int MEM_AW = 32;
    localparam int MEM_DW = 32;

    typedef struct packed {
        logic [MEM_AW-1:0] addr;
        logic [MEM_DW-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Store-to-load forwarding select.
// Walks entries oldest to youngest from head so the youngest hit wins.
module sb_fwd_match
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH)
) (
    input  sb_entry_t         entries [DEPTH],
    input  logic [DEPTH-1:0]  valid,
    input  logic [PW-1:0]     head,
    input  logic [MEM_AW-1:0] ld_addr,
    output logic              hit,
    output logic [MEM_DW-1:0] data
);

    logic [PW-1:0] idx;

    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = head;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (valid[idx] && entries[idx].addr == ld_addr) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between MEM stage and single-port data memory.
// Loads own the port; stores drain in order on idle cycles.
module store_buffer
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = MEM_AW,
    parameter int DW    = MEM_DW,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          st_valid,
    input  logic [AW-1:0] st_addr,
    input  logic [DW-1:0] st_data,
    output logic          st_ready,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    output logic [DW-1:0] ld_data,
    output logic          ld_fwd,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd,
    output logic          empty,
    output logic [CW-1:0] count
);

    if (AW != MEM_AW || DW != MEM_DW) begin : g_width_chk
        $error("store_buffer AW/DW must match mips_mem_pkg");
    end

    sb_entry_t        fifo [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [DEPTH-1:0] valid;
    logic             full;
    logic             enq;
    logic             deq;
    logic             hit;
    logic [DW-1:0]    fwd_data;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign st_ready = !full && !ld_valid;
    assign enq      = st_valid && st_ready;
    assign deq      = !empty && !ld_valid;

    assign mem_we = deq;
    assign mem_a  = ld_valid ? ld_addr : fifo[head].addr;
    assign mem_wd = fifo[head].data;

    // An entry is live when its distance from head is below count.
    always_comb begin
        valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid[i] = CW'(PW'(i) - head) < count;
        end
    end

    sb_fwd_match #(
        .DEPTH (DEPTH)
    ) u_fwd (
        .entries (fifo),
        .valid   (valid),
        .head    (head),
        .ld_addr (ld_addr),
        .hit     (hit),
        .data    (fwd_data)
    );

    assign ld_fwd  = ld_valid && hit;
    assign ld_data = ld_fwd ? fwd_data : mem_rd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(deq);
            tail  <= tail + PW'(enq);
            count <= count + CW'(enq) - CW'(deq);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo[i] <= '0;
            end
        end else if (enq) begin
            fifo[tail] <= '{addr: st_addr, data: st_data};
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer against a queue-based model.
// Environment memory is 16 words indexed by the low address bits.
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          st_valid = 1'b0;
    logic [AW-1:0] st_addr = '0;
    logic [DW-1:0] st_data = '0;
    logic          st_ready;
    logic          ld_valid = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data;
    logic          ld_fwd;
    logic          mem_we;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;
    logic          empty;
    logic [CW-1:0] count;

    logic          pre_we = 1'b0;
    logic [3:0]    pre_a  = '0;
    logic [DW-1:0] pre_d  = '0;
    logic [DW-1:0] dmem [16];

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          q [$];
    logic [DW-1:0] refmem [16];
    int            vectors = 0;
    int            miscompares = 0;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .st_valid (st_valid),
        .st_addr  (st_addr),
        .st_data  (st_data),
        .st_ready (st_ready),
        .ld_valid (ld_valid),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .ld_fwd   (ld_fwd),
        .mem_we   (mem_we),
        .mem_a    (mem_a),
        .mem_wd   (mem_wd),
        .mem_rd   (mem_rd),
        .empty    (empty),
        .count    (count)
    );

    assign mem_rd = dmem[mem_a[3:0]];

    always @(posedge clk) begin
        if (pre_we) dmem[pre_a] <= pre_d;
        else if (mem_we) dmem[mem_a[3:0]] <= mem_wd;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic sv, input logic [AW-1:0] sa,
                        input logic [DW-1:0] sd, input logic lv,
                        input logic [AW-1:0] la);
        int            n;
        logic          e_rdy;
        logic          e_we;
        logic          e_fwd;
        logic [DW-1:0] e_ld;
        assert (!(sv && lv)) else begin
            miscompares++;
            $error("FAIL illegal_st_ld observed=1 expected=0");
        end
        @(negedge clk);
        st_valid = sv; st_addr = sa; st_data = sd;
        ld_valid = lv; ld_addr = la;
        #1;
        n     = q.size();
        e_rdy = (n < DEPTH) && !lv;
        e_we  = (n > 0) && !lv;
        chk("count", 64'(count), 64'(n));
        chk("empty", 64'(empty), 64'(n == 0));
        chk("st_ready", 64'(st_ready), 64'(e_rdy));
        chk("mem_we", 64'(mem_we), 64'(e_we));
        if (lv) begin
            e_fwd = 1'b0;
            e_ld  = refmem[la[3:0]];
            for (int i = n - 1; i >= 0; i--) begin
                if (!e_fwd && q[i].a == la) begin
                    e_fwd = 1'b1;
                    e_ld  = q[i].d;
                end
            end
            chk("ld_mem_a", 64'(mem_a), 64'(la));
            chk("ld_fwd", 64'(ld_fwd), 64'(e_fwd));
            chk("ld_data", 64'(ld_data), 64'(e_ld));
        end else begin
            chk("idle_fwd", 64'(ld_fwd), 64'(0));
            chk("idle_ld_data", 64'(ld_data), 64'(mem_rd));
            if (e_we) begin
                chk("drain_a", 64'(mem_a), 64'(q[0].a));
                chk("drain_wd", 64'(mem_wd), 64'(q[0].d));
            end
        end
        @(posedge clk);
        if (e_we) begin
            refmem[q[0].a[3:0]] = q[0].d;
            void'(q.pop_front());
        end
        if (sv && e_rdy) q.push_back('{a: sa, d: sd});
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic drain_all();
        for (int i = 0; i < 3 * DEPTH && q.size() > 0; i++) idle();
        chk("drain_done", 64'(q.size()), 64'(0));
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            pre_we = 1'b1;
            pre_a  = 4'(i);
            pre_d  = (i == 3) ? 32'h1234 : 32'h5000_0000 + 32'(i);
            refmem[i] = pre_d;
        end
        @(negedge clk);
        pre_we = 1'b0;
        #1;
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_empty", 64'(empty), 64'(1));
        chk("rst_ready", 64'(st_ready), 64'(1));
        chk("rst_we", 64'(mem_we), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        step(1'b1, 32'd5, 32'hAAAA_0001, 1'b0, '0);
        idle();
        idle();
        #1;
        chk("dmem5", 64'(dmem[5]), 64'h0000_0000_AAAA_0001);

        for (int i = 0; i < 4; i++)
            step(1'b1, 32'(8 + i), 32'hB000_0000 + 32'(i), 1'b0, '0);
        for (int i = 0; i < 6; i++)
            step(1'b0, '0, '0, 1'b1, 32'(8 + (i % 4)));
        drain_all();

        step(1'b1, 32'd9, 32'd1, 1'b0, '0);
        step(1'b1, 32'd9, 32'd2, 1'b0, '0);
        step(1'b0, '0, '0, 1'b1, 32'd9);
        drain_all();
        step(1'b0, '0, '0, 1'b1, 32'd9);

        step(1'b0, '0, '0, 1'b1, 32'd3);

        for (int i = 0; i < 3 * DEPTH; i++)
            step(1'b1, 32'(i % 8), 32'hC000_0000 + 32'(i), 1'b0, '0);
        step(1'b1, 32'd2, 32'hC0DE_0002, 1'b0, '0);
        step(1'b0, '0, '0, 1'b1, 32'd2);
        drain_all();

        for (int i = 0; i < 400; i++) begin
            int unsigned op;
            op = $urandom_range(0, 2);
            if (op == 0)
                step(1'b1, 32'($urandom_range(0, 7)), $urandom, 1'b0, '0);
            else if (op == 1)
                step(1'b0, '0, '0, 1'b1, 32'($urandom_range(0, 7)));
            else
                idle();
        end
        drain_all();

        step(1'b1, 32'd12, 32'hBAD0_000C, 1'b0, '0);
        @(negedge clk);
        st_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_count", 64'(count), 64'(0));
        chk("mid_rst_empty", 64'(empty), 64'(1));
        chk("mid_rst_we", 64'(mem_we), 64'(0));
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        idle();
        idle();

        #1;
        for (int i = 0; i < 16; i++)
            chk($sformatf("final_dmem%0d", i), 64'(dmem[i]), 64'(refmem[i]));

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
